// File: rtl/frame_serializer_pkg.sv
// Shared types and defaults for the frame serializer: FSM states, parameter
// defaults, counter width and the parity helper.
package frame_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_SYNC   = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;

    localparam int unsigned SYNC_LEN_DEF   = 32'd8;
    localparam logic [15:0] SYNC_WORD_DEF  = 16'h00A5;
    localparam int unsigned PARITY_ODD_DEF = 32'd0;
    localparam int unsigned CNT_W          = 32'd4;

    // XOR of all payload bits, inverted when odd parity is selected.
    function automatic logic parity8(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Byte handshake between the upstream producer and the frame serializer.
interface frame_serializer_if;
    import frame_serializer_pkg::*;

    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/piso_shift8.sv
// 8-bit parallel-in serial-out register; o_msb is the next payload bit.
module piso_shift8
    import frame_serializer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_shift,
    input  logic [7:0] i_data,
    output logic       o_msb
);

    logic [7:0] r_shift;

    // Load wins over shift; zeros fill from the bottom.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= 8'h00;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= {r_shift[6:0], 1'b0};
        end else begin
            r_shift <= r_shift;
        end
    end

    assign o_msb = r_shift[7];

endmodule

// File: rtl/frame_serializer.sv
// Serializes each accepted byte as sync bits, 8 data bits MSB first and a
// parity bit, one bit per bit_tick.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int unsigned SYNC_LEN   = SYNC_LEN_DEF,
    parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int unsigned PARITY_ODD = PARITY_ODD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_tick,
    frame_serializer_if.slave  bus,
    output logic               tx_out,
    output logic               tx_busy,
    output logic               frame_done
);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 32'd1);
    localparam logic             ODD_BIT   = (PARITY_ODD != 32'd0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             r_parity;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_sync_idx;
    logic             w_tx_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_shift;
    logic             w_msb;

    assign bus.data_ready = (r_state == ST_IDLE);
    assign w_accept       = bus.data_valid && (r_state == ST_IDLE);
    assign w_sync_idx     = r_cnt - 4'd1;

    piso_shift8 u_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (bus.data_in),
        .o_msb   (w_msb)
    );

    // Next-state and next-bit logic; nothing but acceptance happens without a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (bus.data_valid) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (bit_tick) begin
                    w_tx_nxt    = SYNC_WORD[SYNC_LEN-1];
                    w_cnt_nxt   = SYNC_LAST;
                    w_state_nxt = ST_SYNC;
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_SYNC: begin
                if (bit_tick) begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                        w_tx_nxt  = SYNC_WORD[w_sync_idx];
                    end else begin
                        w_tx_nxt    = w_msb;
                        w_shift     = 1'b1;
                        w_cnt_nxt   = 4'd7;
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                        w_tx_nxt  = w_msb;
                        w_shift   = 1'b1;
                    end else begin
                        w_tx_nxt    = r_parity;
                        w_state_nxt = ST_PARITY;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    w_tx_nxt    = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= w_done_nxt;
            r_parity <= w_accept ? parity8(bus.data_in, ODD_BIT) : r_parity;
        end
    end

    assign tx_out     = r_tx;
    assign tx_busy    = r_busy;
    assign frame_done = r_done;

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 The block SHALL expose the parameter `SYNC_LEN`: default 8; number of sync bits per frame; legal range 1..16.
REQ-002 The block SHALL expose the parameter `SYNC_WORD`: default 16'h00A5; sync pattern, lower `SYNC_LEN` bits used, sent MSB first.
REQ-003 The block SHALL expose the parameter `PARITY_ODD`: default 0; 0 selects even parity, 1 selects odd parity.
REQ-004 `clk`  input  1  system clock; all state changes on its rising edge.
REQ-005 `reset`  input  1  reset, asynchronous, active-low.
REQ-006 `bit_tick`  input  1  one-`clk` strobe marking each bit-period boundary; comes from the rate divider stage upstream.
REQ-007 `data_in`  input  8  payload byte.
REQ-008 `data_valid`  input  1  payload byte is offered.
REQ-009 `data_ready`  output  1  block can accept a byte.
REQ-010 `tx_out`  output  1  serial line; idles at 1.
REQ-011 `tx_busy`  output  1  a frame is pending or in progress.
REQ-012 `frame_done`  output  1  one-`clk` pulse at the end of a frame.

Function
REQ-013 States SHALL be IDLE, ARMED, SYNC, DATA and PARITY.
REQ-014 `data_ready` SHALL equal (state==IDLE), combinationally.
REQ-015 A byte SHALL be accepted on the `clk` edge where `data_valid` and `data_ready` are both 1.
  - `data_in` is latched.
  - Even or odd parity of the byte is latched.
  - State goes IDLE->ARMED.
REQ-016 A `bit_tick` coincident with acceptance SHALL be ignored; the first bit starts on the next `bit_tick`.
REQ-017 Outside acceptance, state and `tx_out` SHALL change only on `clk` edges where `bit_tick`=1.
REQ-018 ARMED on tick: `tx_out` <= `SYNC_WORD`[`SYNC_LEN`-1]; state goes to SYNC; bit counter <= `SYNC_LEN`-1.
REQ-019 SYNC on tick:
  - counter>0: decrement the counter and output the next lower sync bit.
  - counter==0: output `data`[7], go to DATA, counter <= 7.
REQ-020 DATA on tick:
  - counter>0: decrement the counter and output the next lower data bit (MSB first).
  - counter==0: output the parity bit and go to PARITY.
REQ-021 PARITY on tick: `tx_out` <= 1, state goes to IDLE, `frame_done`=1 for exactly that one cycle.
REQ-022 Each frame SHALL occupy exactly `SYNC_LEN`+9 bit periods on the line.
REQ-023 Each bit SHALL be held stable between consecutive ticks.
REQ-024 `tx_busy` SHALL be 1 in ARMED, SYNC, DATA and PARITY, and 0 in IDLE.
REQ-025 Back-to-back frames:
  - `data_valid` held high in the cycle after `frame_done` SHALL be accepted, since IDLE holds for at least one cycle.
  - That frame's first sync bit starts on the following tick.
  - The line idles (1) for at least one bit period between frames.
REQ-026 `data_valid` and `data_in` changes while not IDLE SHALL have no effect on the frame in progress.
REQ-027 `bit_tick` held high continuously SHALL advance one bit per `clk`, with no skipped or repeated bits.
REQ-028 `data_in` SHALL be treated as 8-bit unsigned; the parity bit SHALL be XOR of all 8 bits, XOR `PARITY_ODD`.

Reset
REQ-029 While `reset`=0 the block SHALL force:
  - state IDLE;
  - `tx_out`=1, `tx_busy`=0, `frame_done`=0, `data_ready`=1;
  - counter 0, shift and parity registers 0.
REQ-030 Reset assertion mid-frame SHALL abort the frame immediately with no further bits emitted; no `frame_done` SHALL be generated for an aborted frame.
REQ-031 After reset release, the first `clk` edge SHALL be able to accept a byte.

Structure
REQ-032 A shared package SHALL hold:
  - the state enumeration;
  - default constants for `SYNC_LEN`, `SYNC_WORD` and `PARITY_ODD`;
  - the counter width (4 bits).
REQ-033 One sub-module `piso_shift8` SHALL implement the load/shift 8-bit parallel-in serial-out register; the FSM and sync/parity muxing stay in `frame_serializer`.

Verification
REQ-034 Defaults, `data_in`=8'h3C accepted, tick every 4 clk -> `tx_out` sequence 1010_0101_0011_1100_0 over 17 ticks; then `frame_done` pulses once and `tx_out` returns to 1.
REQ-035 `PARITY_ODD`=1, `data_in`=8'h01 -> parity bit 0; with `PARITY_ODD`=0, parity bit 1.
REQ-036 `data_valid` asserted together with `bit_tick` in IDLE -> accepted; line stays 1 until the next tick, then the first bit 1 (`SYNC_WORD` MSB) appears.
REQ-037 `data_valid` held high continuously with bytes 8'hFF then 8'h00 -> second accepted one cycle after `frame_done`; exactly one idle bit period between frames; 34 frame bits total.
REQ-038 `reset` pulled low at the 5th data bit -> `tx_out`=1 and `data_ready`=1 within the same cycle (asynchronous); no `frame_done`; a new frame after release is correct.
REQ-039 `bit_tick` tied high, `SYNC_LEN`=1 -> 10 consecutive clk cycles carry the 10 frame bits; `tx_busy` high from acceptance until the `frame_done` cycle.
